tl45_decode: RTL and testbench

//  Decode / operand-fetch stage of the TL45 pipeline. Feeds the ALU stage's input buffer.

---
 rtl/tl45_pkg.sv | 53 +++++
 rtl/tl45_operand_fwd.sv | 29 ++
 rtl/tl45_decode.sv | 130 +++++++++++++
 tb/tb_tl45_decode.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tl45_pkg : shared opcodes, instruction field layout and helpers          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package tl45_pkg;

  localparam logic [4:0] C_OPC_NOP     = 5'h00;
  localparam logic [4:0] C_OPC_ADD     = 5'h01;
  localparam logic [4:0] C_OPC_BR      = 5'h0C;
  localparam logic [4:0] C_OPC_LW      = 5'h14;
  localparam logic [3:0] C_JMP_ALWAYS  = 4'hF;
  localparam logic [3:0] C_RF_ZERO_REG = 4'd0;

  // sr2 and hi/imm16 overlap in the encoding, so the split is done by function.
  typedef struct packed {
    logic [4:0]  opc;
    logic        imm_mode;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic        hi;
    logic [15:0] imm16;
  } tl45_fields_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  jmp_cond;
    logic [31:0] sr1_val;
    logic [31:0] sr2_val;
    logic [31:0] target_offset;
    logic [31:0] pc;
  } tl45_dec_t;

  function automatic tl45_fields_t tl45_split(input logic [31:0] instr);
    tl45_fields_t f;
    f.opc      = instr[31:27];
    f.imm_mode = instr[26];
    f.dr       = instr[25:22];
    f.sr1      = instr[21:18];
    f.sr2      = instr[17:14];
    f.hi       = instr[16];
    f.imm16    = instr[15:0];
    return f;
  endfunction

  function automatic logic [31:0] tl45_imm_ext(input logic hi, input logic [15:0] imm16);
    return hi ? {imm16, 16'h0000} : {{16{imm16[15]}}, imm16};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl45_operand_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tl45_operand_fwd : zero-register squash plus ALU/WB forwarding mux       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tl45_operand_fwd
  import tl45_pkg::*;
#(
  parameter logic [3:0] RF_ZERO_REG = C_RF_ZERO_REG
) (
  input  logic [3:0]  i_idx,
  input  logic [31:0] i_rf_val,
  input  logic [3:0]  i_of1_reg,
  input  logic [31:0] i_of1_val,
  input  logic [3:0]  i_of2_reg,
  input  logic [31:0] i_of2_val,
  output logic [31:0] o_val
);

  // A forward tagged with the zero register can never match: the squash is tested first.
  always_comb begin
    if (i_idx == RF_ZERO_REG)    o_val = '0;
    else if (i_idx == i_of1_reg) o_val = i_of1_val;
    else if (i_idx == i_of2_reg) o_val = i_of2_val;
    else                         o_val = i_rf_val;
  end

endmodule
`default_nettype wire

// File: rtl/tl45_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tl45_decode : decode / operand-fetch stage with load-use bubble          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tl45_decode
  import tl45_pkg::*;
#(
  parameter logic [3:0] RF_ZERO_REG = C_RF_ZERO_REG,
  parameter logic [4:0] OPC_LW      = C_OPC_LW,
  parameter logic [4:0] OPC_BR      = C_OPC_BR
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [3:0]  o_rf_sr1_addr,
  output logic [3:0]  o_rf_sr2_addr,
  input  logic [31:0] i_rf_sr1_val,
  input  logic [31:0] i_rf_sr2_val,
  input  logic [3:0]  i_of1_reg,
  input  logic [31:0] i_of1_val,
  input  logic [3:0]  i_of2_reg,
  input  logic [31:0] i_of2_val,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_jmp_cond,
  output logic [31:0] o_sr1_val,
  output logic [31:0] o_sr2_val,
  output logic [31:0] o_target_offset,
  output logic [31:0] o_pc
);

  tl45_fields_t w_f;
  tl45_dec_t    w_nxt;
  tl45_dec_t    r_buf;
  logic         w_is_branch;
  logic         w_uses_sr2;
  logic         w_hazard_stall;
  logic         w_clear;
  logic         w_capture;
  logic [31:0]  w_imm;
  logic [31:0]  w_sr1_fwd;
  logic [31:0]  w_sr2_fwd;
  logic         r_ld_valid;
  logic [3:0]   r_ld_dr;

  assign w_f         = tl45_split(i_instr);
  assign w_is_branch = (w_f.opc == OPC_BR);
  // Branches carry their offset where sr2 would sit, so sr2 is only a real source here.
  assign w_uses_sr2  = !w_f.imm_mode && !w_is_branch;
  assign w_imm       = tl45_imm_ext(w_f.hi, w_f.imm16);

  assign o_rf_sr1_addr = w_f.sr1;
  assign o_rf_sr2_addr = w_f.sr2;

  tl45_operand_fwd #(.RF_ZERO_REG(RF_ZERO_REG)) u_fwd_sr1 (
    .i_idx     (w_f.sr1),
    .i_rf_val  (i_rf_sr1_val),
    .i_of1_reg (i_of1_reg),
    .i_of1_val (i_of1_val),
    .i_of2_reg (i_of2_reg),
    .i_of2_val (i_of2_val),
    .o_val     (w_sr1_fwd)
  );

  tl45_operand_fwd #(.RF_ZERO_REG(RF_ZERO_REG)) u_fwd_sr2 (
    .i_idx     (w_f.sr2),
    .i_rf_val  (i_rf_sr2_val),
    .i_of1_reg (i_of1_reg),
    .i_of1_val (i_of1_val),
    .i_of2_reg (i_of2_reg),
    .i_of2_val (i_of2_val),
    .o_val     (w_sr2_fwd)
  );

  assign w_hazard_stall = r_ld_valid && (r_ld_dr != RF_ZERO_REG) &&
                          ((r_ld_dr == w_f.sr1) || (w_uses_sr2 && (r_ld_dr == w_f.sr2)));

  assign o_pipe_stall = i_pipe_stall | w_hazard_stall;
  assign o_pipe_flush = i_pipe_flush;

  assign w_clear   = i_pipe_flush || (!i_pipe_stall && w_hazard_stall);
  assign w_capture = !i_pipe_flush && !i_pipe_stall && !w_hazard_stall;

  always_comb begin
    w_nxt         = '0;
    w_nxt.opcode  = w_f.opc;
    w_nxt.sr1_val = w_sr1_fwd;
    w_nxt.pc      = i_pc;
    if (w_is_branch) begin
      w_nxt.jmp_cond      = w_f.dr;
      w_nxt.target_offset = tl45_imm_ext(1'b0, w_f.imm16);
    end else begin
      w_nxt.dr      = w_f.dr;
      w_nxt.sr2_val = w_f.imm_mode ? w_imm : w_sr2_fwd;
    end
  end

  // Cleared buffer doubles as the NOP bubble; the tracker clears with it so a retry never re-stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf      <= '0;
      r_ld_valid <= 1'b0;
      r_ld_dr    <= '0;
    end else if (w_clear) begin
      r_buf      <= '0;
      r_ld_valid <= 1'b0;
      r_ld_dr    <= '0;
    end else if (w_capture) begin
      r_buf      <= w_nxt;
      r_ld_valid <= (w_f.opc == OPC_LW);
      r_ld_dr    <= w_f.dr;
    end
  end

  assign o_opcode        = r_buf.opcode;
  assign o_dr            = r_buf.dr;
  assign o_jmp_cond      = r_buf.jmp_cond;
  assign o_sr1_val       = r_buf.sr1_val;
  assign o_sr2_val       = r_buf.sr2_val;
  assign o_target_offset = r_buf.target_offset;
  assign o_pc            = r_buf.pc;

endmodule
`default_nettype wire

// File: tb/tb_tl45_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tl45_decode : scoreboard bench for the TL45 decode stage              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tl45_decode;
  import tl45_pkg::*;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  jmp;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic [31:0] tgt;
    logic [31:0] pc;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, flush_in, stall_out, flush_out;
  logic [31:0] instr, pc;
  logic [3:0]  sr1_addr, sr2_addr;
  logic [31:0] sr1_rf, sr2_rf;
  logic [3:0]  of1_reg, of2_reg;
  logic [31:0] of1_val, of2_val;
  logic [4:0]  opcode;
  logic [3:0]  dr, jmp_cond;
  logic [31:0] sr1_val, sr2_val, target_offset, pc_out;
  logic [31:0] rf [16];

  out_t exp_q[$];
  out_t ob, ex, hold;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign sr1_rf = rf[sr1_addr];
  assign sr2_rf = rf[sr2_addr];

  tl45_decode dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_pipe_stall(stall_in), .i_pipe_flush(flush_in),
    .o_pipe_stall(stall_out), .o_pipe_flush(flush_out),
    .i_instr(instr), .i_pc(pc),
    .o_rf_sr1_addr(sr1_addr), .o_rf_sr2_addr(sr2_addr),
    .i_rf_sr1_val(sr1_rf), .i_rf_sr2_val(sr2_rf),
    .i_of1_reg(of1_reg), .i_of1_val(of1_val),
    .i_of2_reg(of2_reg), .i_of2_val(of2_val),
    .o_opcode(opcode), .o_dr(dr), .o_jmp_cond(jmp_cond),
    .o_sr1_val(sr1_val), .o_sr2_val(sr2_val),
    .o_target_offset(target_offset), .o_pc(pc_out)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] opc, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2);
    return {opc, 1'b0, d, s1, s2, 14'h0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] opc, input logic [3:0] d,
                                        input logic [3:0] s1, input logic hi, input logic [15:0] imm);
    return {opc, 1'b1, d, s1, 1'b0, hi, imm};
  endfunction

  function automatic logic [31:0] enc_b(input logic [3:0] cond, input logic [3:0] s1,
                                        input logic [15:0] imm);
    return {C_OPC_BR, 1'b0, cond, s1, 2'b00, imm};
  endfunction

  function automatic logic [31:0] opsel(input logic [3:0] idx);
    if (idx == 4'd0)         return 32'h0;
    else if (idx == of1_reg) return of1_val;
    else if (idx == of2_reg) return of2_val;
    else                     return rf[idx];
  endfunction

  function automatic out_t model(input logic [31:0] ins, input logic [31:0] p);
    out_t        m;
    logic [15:0] imm16;
    logic [31:0] imm;
    imm16    = ins[15:0];
    imm      = ins[16] ? {imm16, 16'h0} : {{16{imm16[15]}}, imm16};
    m        = '0;
    m.opcode = ins[31:27];
    m.pc     = p;
    m.sr1    = opsel(ins[21:18]);
    if (ins[31:27] == 5'h0C) begin
      m.jmp = ins[25:22];
      m.tgt = {{16{imm16[15]}}, imm16};
    end else begin
      m.dr  = ins[25:22];
      m.sr2 = ins[26] ? imm : opsel(ins[17:14]);
    end
    return m;
  endfunction

  function automatic out_t observe();
    return {opcode, dr, jmp_cond, sr1_val, sr2_val, target_offset, pc_out};
  endfunction

  // Drive one instruction, record its expected output, and advance past the capturing edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] p);
    instr = ins;
    pc    = p;
    #1;
    exp_q.push_back(model(ins, p));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    instr = enc_r(C_OPC_ADD, 4'd3, 4'd1, 4'd2); pc = 32'h55;
    of1_reg = '0; of1_val = '0; of2_reg = '0; of2_val = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    ob = observe(); total++;
    if (ob !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", ob); end
    instr = '0;
    #1;
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    rf[1] = 32'd5; rf[2] = 32'd7;
    issue(enc_r(C_OPC_ADD, 4'd3, 4'd1, 4'd2), 32'h100);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_basic: got %h want %h", ob, ex); end
    total++;
    if (opcode !== 5'd1 || dr !== 4'd3 || sr1_val !== 32'd5 || sr2_val !== 32'd7) begin
      bad++; $display("FAIL add_fields: got op=%h dr=%h s1=%h s2=%h want 1 3 5 7", opcode, dr, sr1_val, sr2_val);
    end
    issue(enc_i(C_OPC_ADD, 4'd6, 4'd1, 1'b0, 16'h8001), 32'h104);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL addi_sext: got %h want %h", ob, ex); end
    total++;
    if (sr2_val !== 32'hFFFF_8001) begin bad++; $display("FAIL addi_sext_val: got %h want ffff8001", sr2_val); end
    issue(enc_i(C_OPC_ADD, 4'd6, 4'd2, 1'b1, 16'h1234), 32'h108);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL addi_hi: got %h want %h", ob, ex); end
    issue(enc_r(5'h1F, 4'd9, 4'd0, 4'd2), 32'h10C);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL unknown_r0: got %h want %h", ob, ex); end
  endtask

  task automatic test_forward();
    of1_reg = 4'd1; of1_val = 32'd9; of2_reg = 4'd1; of2_val = 32'd4;
    issue(enc_r(C_OPC_ADD, 4'd3, 4'd1, 4'd2), 32'h110);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL fwd_model: got %h want %h", ob, ex); end
    total++;
    if (sr1_val !== 32'd9) begin bad++; $display("FAIL fwd_of1_wins: got %h want 9", sr1_val); end
    of1_reg = 4'd0; of1_val = 32'h77; of2_reg = 4'd2; of2_val = 32'h55;
    issue(enc_r(C_OPC_ADD, 4'd3, 4'd0, 4'd2), 32'h114);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL fwd_of2_r0: got %h want %h", ob, ex); end
    total++;
    if (sr1_val !== 32'h0 || sr2_val !== 32'h55) begin
      bad++; $display("FAIL fwd_of2_vals: got s1=%h s2=%h want 0 55", sr1_val, sr2_val);
    end
    of1_reg = '0; of1_val = '0; of2_reg = '0; of2_val = '0;
  endtask

  task automatic test_load_use();
    issue(enc_i(C_OPC_LW, 4'd4, 4'd1, 1'b0, 16'h0008), 32'h200);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL lw: got %h want %h", ob, ex); end
    instr = enc_r(C_OPC_ADD, 4'd5, 4'd4, 4'd2); pc = 32'h204;
    #1; total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL hazard_stall: got %b want 1", stall_out); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL bubble: got %h want %h", ob, ex); end
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL retry_no_stall: got %b want 0", stall_out); end
    issue(instr, pc);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_after_bubble: got %h want %h", ob, ex); end
    // sr2 dependency
    issue(enc_i(C_OPC_LW, 4'd4, 4'd1, 1'b0, 16'h0010), 32'h208);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL lw2: got %h want %h", ob, ex); end
    instr = enc_r(C_OPC_ADD, 4'd5, 4'd2, 4'd4);
    #1; total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL hazard_sr2: got %b want 1", stall_out); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL bubble_sr2: got %h want %h", ob, ex); end
    issue(instr, 32'h20C);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_sr2_after: got %h want %h", ob, ex); end
    // immediate bits that alias sr2=6 must not stall
    issue(enc_i(C_OPC_LW, 4'd6, 4'd1, 1'b0, 16'h0000), 32'h210);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL lw3: got %h want %h", ob, ex); end
    instr = enc_i(C_OPC_ADD, 4'd7, 4'd1, 1'b1, 16'h8000);
    #1; total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL imm_no_sr2_hazard: got %b want 0", stall_out); end
    issue(instr, 32'h214);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL addi_after_lw: got %h want %h", ob, ex); end
  endtask

  task automatic test_branch();
    rf[2] = 32'h100;
    issue(enc_b(4'd4, 4'd2, 16'hFFF8), 32'h300);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL branch: got %h want %h", ob, ex); end
    total++;
    if (jmp_cond !== 4'd4 || target_offset !== 32'hFFFF_FFF8 || dr !== 4'd0 ||
        sr1_val !== 32'h100 || sr2_val !== 32'h0) begin
      bad++; $display("FAIL branch_fields: got jc=%h off=%h dr=%h s1=%h s2=%h want 4 fffffff8 0 100 0",
                      jmp_cond, target_offset, dr, sr1_val, sr2_val);
    end
    issue(enc_b(C_JMP_ALWAYS, 4'd1, 16'h0010), 32'h304);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL branch_always: got %h want %h", ob, ex); end
  endtask

  task automatic test_stall_flush();
    issue(enc_r(C_OPC_ADD, 4'd3, 4'd1, 4'd2), 32'h400);
    hold = exp_q.pop_front(); ob = observe(); total++;
    if (ob !== hold) begin bad++; $display("FAIL pre_stall: got %h want %h", ob, hold); end
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr = enc_r(C_OPC_ADD, 4'(i + 8), 4'(i + 1), 4'(14 - i)); pc = 32'h500 + i;
      exp_q.push_back(hold);
      @(posedge clk); #1;
      ob = observe(); ex = exp_q.pop_front(); total++;
      if (ob !== ex) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", i, ob, ex); end
    end
    flush_in = 1'b1;
    #1; total++;
    if (flush_out !== 1'b1) begin bad++; $display("FAIL flush_pass: got %b want 1", flush_out); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL flush_clear: got %h want %h", ob, ex); end
    flush_in = 1'b0; stall_in = 1'b0;
    // tracker must survive a downstream stall
    issue(enc_i(C_OPC_LW, 4'd4, 4'd1, 1'b0, 16'h0004), 32'h600);
    hold = exp_q.pop_front();
    stall_in = 1'b1;
    instr = enc_r(C_OPC_ADD, 4'd5, 4'd4, 4'd2); pc = 32'h604;
    exp_q.push_back(hold);
    @(posedge clk); #1;
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL stall_hold_lw: got %h want %h", ob, ex); end
    stall_in = 1'b0;
    #1; total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL tracker_held: got %b want 1", stall_out); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL bubble_after_stall: got %h want %h", ob, ex); end
    issue(instr, pc);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_after_stall: got %h want %h", ob, ex); end
    // flush clears the tracker
    issue(enc_i(C_OPC_LW, 4'd4, 4'd1, 1'b0, 16'h0004), 32'h700);
    void'(exp_q.pop_front());
    flush_in = 1'b1; instr = '0;
    @(posedge clk); #1;
    flush_in = 1'b0;
    instr = enc_r(C_OPC_ADD, 4'd5, 4'd4, 4'd2); pc = 32'h704;
    #1; total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_clears_tracker: got %b want 0", stall_out); end
    issue(instr, pc);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_after_flush: got %h want %h", ob, ex); end
  endtask

  task automatic test_reset_mid_hazard();
    issue(enc_i(C_OPC_LW, 4'd4, 4'd1, 1'b0, 16'h0020), 32'h800);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL lw_pre_reset: got %h want %h", ob, ex); end
    instr = enc_r(C_OPC_ADD, 4'd5, 4'd4, 4'd2); pc = 32'h804;
    #1; total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL hazard_pre_reset: got %b want 1", stall_out); end
    reset_n = 1'b0;
    #1;
    ob = observe(); total++;
    if (ob !== '0) begin bad++; $display("FAIL reset_async_clear: got %h want 0", ob); end
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_no_stall: got %b want 0", stall_out); end
    #1 reset_n = 1'b1;
    issue(instr, pc);
    ob = observe(); ex = exp_q.pop_front(); total++;
    if (ob !== ex) begin bad++; $display("FAIL add_after_reset: got %h want %h", ob, ex); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_branch();
    test_stall_flush();
    test_reset_mid_hazard();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
